// File: rtl/apb_slave_regs.sv
// ----------------------------------------------------------------------------
// apb_slave_regs
//   APB register-bank responder. Decodes an APB transfer, inserts a fixed
//   number of wait states, then completes with registered pready/prdata.
//   Register 0 is exported as a control word. The top register is a
//   read-only count of completed transfers.
//
// Optional feature macro: APB_SLV_ERR_EN
//   defined   : pslverr rises with pready for a miss or a write to the counter
//   undefined : pslverr stays 0
//
// Parameters
//   BASE_ADDR    byte base address of the register window
//   NUM_REGS     number of 32-bit registers (power of 2, >= 2)
//   WAIT_STATES  wait cycles between SETUP and pready (0..15)
//
// Ports
//   HCLK      in   clock, rising edge
//   HRESET    in   asynchronous reset, active-low
//   pselx     in   slave select
//   penable   in   ACCESS-phase strobe
//   pwrite    in   1=write, 0=read
//   paddr     in   byte address, bits [1:0] ignored
//   pwdata    in   write data
//   prdata    out  read data, valid while pready=1
//   pready    out  transfer complete (registered)
//   pslverr   out  error response (registered)
//   ctrl_out  out  current value of register 0
// ----------------------------------------------------------------------------
module apb_slave_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] ctrl_out
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_REGS - 1);
  // 33-bit bounds so a window ending at the top of the address space
  // cannot wrap the comparison.
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * NUM_REGS) - 33'd1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

`ifdef APB_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  // Entry NUM_REGS-1 of the array is never written; that slot is served
  // by xfer_cnt_q on reads.
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  function automatic logic addr_hit(input logic [31:0] a);
    return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} <= ADDR_HI);
  endfunction

  function automatic logic [IDXW-1:0] addr_idx(input logic [31:0] a);
    return a[2 +: IDXW];
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (!addr_hit(a))            return 32'h0;
    else if (addr_idx(a) == LAST) return xfer_cnt_q;
    else                         return regs_q[addr_idx(a)];
  endfunction

  function automatic logic err_word(input logic [31:0] a, input logic w);
    return ERR_EN && (!addr_hit(a) || (w && addr_idx(a) == LAST));
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    regs_d     = regs_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      S_IDLE: begin
        // penable without a preceding SETUP is ignored here.
        if (pselx && !penable) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          if (WAIT_STATES == 0) begin
            // No latch yet, so decode straight off the bus.
            pready_d  = 1'b1;
            prdata_d  = rd_word(paddr);
            pslverr_d = err_word(paddr, pwrite);
            state_d   = S_READY;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!pselx) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            prdata_d  = rd_word(addr_q);
            pslverr_d = err_word(addr_q, wr_q);
            state_d   = S_READY;
          end
        end
      end
      S_READY: begin
        if (!pselx) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = S_IDLE;
        end else if (penable) begin
          if (wr_q && addr_hit(addr_q) && addr_idx(addr_q) != LAST)
            regs_d[addr_idx(addr_q)] = wdata_q;
          // prdata already holds the pre-increment count for counter reads.
          xfer_cnt_d = xfer_cnt_q + 32'd1;
          pready_d   = 1'b0;
          pslverr_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      regs_q     <= '{default: '0};
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      regs_q     <= regs_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign ctrl_out = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_regs
//   Directed bench for apb_slave_regs. Three instances with WAIT_STATES of
//   0, 1 and 3 share the APB bus but each has its own select line, so a
//   transfer addresses exactly one of them.
// ----------------------------------------------------------------------------
module tb_apb_slave_regs;

`ifdef APB_SLV_ERR_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        HCLK;
  logic        HRESET;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prd [3];
  logic [2:0]  rdy;
  logic [2:0]  err;
  logic [31:0] ctl [3];

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] rd;
  logic        e;
  logic        seen;

  apb_slave_regs #(.WAIT_STATES(0)) u_w0 (
    .HCLK(HCLK), .HRESET(HRESET), .pselx(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prd[0]),
    .pready(rdy[0]), .pslverr(err[0]), .ctrl_out(ctl[0]));

  apb_slave_regs #(.WAIT_STATES(1)) u_w1 (
    .HCLK(HCLK), .HRESET(HRESET), .pselx(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prd[1]),
    .pready(rdy[1]), .pslverr(err[1]), .ctrl_out(ctl[1]));

  apb_slave_regs #(.WAIT_STATES(3)) u_w3 (
    .HCLK(HCLK), .HRESET(HRESET), .pselx(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prd[2]),
    .pready(rdy[2]), .pslverr(err[2]), .ctrl_out(ctl[2]));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transfer on instance inst. Latency is the number of rising
  // edges from the SETUP cycle until pready is seen; expected WAIT_STATES+1.
  task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rdo, output logic eo);
    int lat;
    int exp_lat;
    exp_lat = (inst == 0) ? 1 : (inst == 1) ? 2 : 4;
    @(negedge HCLK);
    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge HCLK);
    penable = 1'b1;
    lat = 1;
    while (!rdy[inst] && lat < 40) begin
      @(negedge HCLK);
      lat++;
    end
    rdo = prd[inst];
    eo  = err[inst];
    chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge HCLK);
    psel[inst] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    HRESET = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_pready",  {31'd0, rdy[1]}, 32'd0);
    chk("rst_prdata",  prd[1],          32'd0);
    chk("rst_pslverr", {31'd0, err[1]}, 32'd0);
    chk("rst_ctrl",    ctl[1],          32'd0);
    HRESET = 1'b1;

    // Basic write, one wait state
    xfer(1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, rd, e);
    chk("t1_ctrl", ctl[1], 32'hDEAD_BEEF);
    chk("t1_err",  {31'd0, e}, 32'd0);

    // Zero wait states
    xfer(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, rd, e);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, e);
    chk("w0_rd", rd, 32'h0BAD_F00D);

    // Reset pulse clears the bank
    @(negedge HCLK); HRESET = 1'b0;
    @(negedge HCLK); HRESET = 1'b1;
    chk("rst2_ctrl", ctl[1], 32'd0);

    // Read-back, counter, misses (instance w1, counter from 0)
    xfer(1, 1'b1, 32'h8000_0004, 32'h1234_5678, rd, e);  // cnt->1
    xfer(1, 1'b0, 32'h8000_0004, 32'h0, rd, e);          // cnt->2
    chk("t2_rd",  rd, 32'h1234_5678);
    chk("t2_err", {31'd0, e}, 32'd0);
    xfer(1, 1'b0, 32'h8000_001C, 32'h0, rd, e);          // cnt->3
    chk("t2_cnt", rd, 32'd2);
    xfer(1, 1'b1, 32'h8000_001C, 32'h0000_0055, rd, e);  // cnt->4
    chk("cntwr_err", {31'd0, e}, EXP_ERR);
    xfer(1, 1'b0, 32'h8000_001C, 32'h0, rd, e);          // cnt->5
    chk("cntwr_ignored", rd, 32'd4);
    xfer(1, 1'b0, 32'h9000_0000, 32'h0, rd, e);          // cnt->6
    chk("t3_rd",  rd, 32'h0);
    chk("t3_err", {31'd0, e}, EXP_ERR);
    xfer(1, 1'b1, 32'h8000_0020, 32'h0000_AAAA, rd, e);  // cnt->7
    chk("above_err", {31'd0, e}, EXP_ERR);
    xfer(1, 1'b0, 32'h7FFF_FFFC, 32'h0, rd, e);          // cnt->8
    chk("below_rd", rd, 32'h0);
    xfer(1, 1'b0, 32'h8000_001C, 32'h0, rd, e);          // cnt->9
    chk("t3_cnt", rd, 32'd8);
    chk("t3_ctrl", ctl[1], 32'd0);

    // Three wait states, abort in WAIT (instance w3)
    xfer(2, 1'b1, 32'h8000_0008, 32'h1111_1111, rd, e);  // cnt->1
    xfer(2, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, rd, e);  // cnt->2
    chk("w3_ctrl", ctl[2], 32'hCAFE_F00D);
    @(negedge HCLK);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0008; pwdata = 32'h2222_2222;
    @(negedge HCLK); penable = 1'b1;
    @(negedge HCLK); psel[2] = 1'b0; penable = 1'b0;
    seen = rdy[2];
    repeat (6) begin
      @(negedge HCLK);
      if (rdy[2]) seen = 1'b1;
    end
    chk("t4_no_ready", {31'd0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h8000_0008, 32'h0, rd, e);          // cnt->3
    chk("t4_reg", rd, 32'h1111_1111);
    xfer(2, 1'b0, 32'h8000_001C, 32'h0, rd, e);          // cnt->4
    chk("t4_cnt", rd, 32'd3);

    // Counter wrap
    @(negedge HCLK);
    force u_w1.xfer_cnt_q = 32'hFFFF_FFFF;
    @(posedge HCLK); #1;
    release u_w1.xfer_cnt_q;
    xfer(1, 1'b1, 32'h8000_0004, 32'h0, rd, e);          // wraps to 0
    xfer(1, 1'b0, 32'h8000_001C, 32'h0, rd, e);
    chk("t5_wrap", rd, 32'd0);

    // Reset in the middle of a WAIT
    @(negedge HCLK);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0004; pwdata = 32'h7777_7777;
    @(negedge HCLK); penable = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    chk("t6_pready", {31'd0, rdy[2]}, 32'd0);
    chk("t6_prdata", prd[2], 32'd0);
    chk("t6_ctrl",   ctl[2], 32'd0);
    chk("t6_err",    {31'd0, err[2]}, 32'd0);
    psel[2] = 1'b0; penable = 1'b0;
    @(negedge HCLK); HRESET = 1'b1;
    xfer(2, 1'b1, 32'h8000_0000, 32'h5A5A_5A5A, rd, e);
    chk("t6_post_ctrl", ctl[2], 32'h5A5A_5A5A);
    xfer(2, 1'b0, 32'h8000_0004, 32'h0, rd, e);
    chk("t6_no_write", rd, 32'h0);
    xfer(2, 1'b0, 32'h8000_001C, 32'h0, rd, e);
    chk("t6_cnt", rd, 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
